cdf_builder: RTL and testbench

- Produces the CDF table and normalisation constants consumed by the histogram-equalisation output pipeline.
- Reads the per-bin histogram counts from the M1 scratchpad and forms a running prefix sum.
- Writes one CDF entry per bin into the M2 scratchpad.
- Registers CdfMin and divisor for the output stage, then pulses done so the output pipeline can be started.

---
 rtl/cdf_builder.sv | 156 +++++++++++++++
 tb/tb_cdf_builder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdf_builder.sv
// Builds the cumulative histogram (CDF) from M1 scratchpad counts into M2,
// then publishes CdfMin and divisor for the equalisation output stage.
module cdf_builder #(
  parameter int                NUM_BINS  = 256,
  parameter int                COUNT_W   = 20,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] HIST_BASE = '0,
  parameter logic [ADDR_W-1:0] CDF_BASE  = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  M1SP_ReadAddress,
  input  logic [127:0]       M1SP_ReadBus,
  output logic               M2SP_WriteEnable,
  output logic [ADDR_W-1:0]  M2SP_WriteAddress,
  output logic [127:0]       M2SP_WriteBus,
  output logic [COUNT_W-1:0] CdfMin,
  output logic [COUNT_W-1:0] divisor,
  output logic               done
);

  localparam int               IDX_W    = $clog2(NUM_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drain_q, drain_d;
  logic               cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic [COUNT_W-1:0] acc_q, acc_d;
  logic               min_found_q, min_found_d;
  logic [COUNT_W-1:0] min_run_q, min_run_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COUNT_W-1:0] wr_data_q, wr_data_d;
  logic [COUNT_W-1:0] cdf_min_q, cdf_min_d;
  logic [COUNT_W-1:0] divisor_q, divisor_d;

  logic               clear_run;
  logic [COUNT_W:0]   sum;
  logic [COUNT_W-1:0] acc_sat;
  logic [COUNT_W-1:0] diff;
  logic               unused_bits;

  assign unused_bits = ^M1SP_ReadBus[127:COUNT_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    clear_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          idx_d     = '0;
          clear_run = 1'b1;
        end
      end
      READ: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture stage sees the count one cycle after its address; the sum is one
  // bit wider so overflow clamps to all-ones and then stays there.
  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, M1SP_ReadBus[COUNT_W-1:0]};
    acc_sat     = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    cap_valid_d = (state_q == READ);
    cap_idx_d   = idx_q;
    acc_d       = acc_q;
    min_found_d = min_found_q;
    min_run_d   = min_run_q;
    if (clear_run) begin
      acc_d       = '0;
      min_found_d = 1'b0;
      min_run_d   = '0;
    end else if (cap_valid_q) begin
      acc_d = acc_sat;
      if (!min_found_q && (acc_sat != '0)) begin
        min_found_d = 1'b1;
        min_run_d   = acc_sat;
      end
    end
    wr_en_d   = cap_valid_q;
    wr_addr_d = cap_valid_q ? CDF_BASE + ADDR_W'(cap_idx_q) : '0;
    wr_data_d = cap_valid_q ? acc_sat : '0;
  end

  // Results are latched as FINISH is entered so they are valid alongside done.
  always_comb begin
    diff      = acc_q - min_run_q;
    cdf_min_d = cdf_min_q;
    divisor_d = divisor_q;
    if (state_q == DRAIN && drain_q) begin
      cdf_min_d = min_run_q;
      divisor_d = (diff == '0) ? COUNT_W'(1) : diff;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      acc_q       <= '0;
      min_found_q <= 1'b0;
      min_run_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cdf_min_q   <= '0;
      divisor_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      acc_q       <= acc_d;
      min_found_q <= min_found_d;
      min_run_q   <= min_run_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cdf_min_q   <= cdf_min_d;
      divisor_q   <= divisor_d;
    end
  end

  assign M1SP_ReadAddress  = (state_q == READ) ? HIST_BASE + ADDR_W'(idx_q) : '0;
  assign M2SP_WriteEnable  = wr_en_q;
  assign M2SP_WriteAddress = wr_addr_q;
  assign M2SP_WriteBus     = {{(128 - COUNT_W){1'b0}}, wr_data_q};
  assign CdfMin            = cdf_min_q;
  assign divisor           = divisor_q;
  assign done              = (state_q == FINISH);

endmodule

// File: tb/tb_cdf_builder.sv
// Directed bench for cdf_builder: table of histogram patterns with expected
// CDF probes and constants, plus reset-abort and held-start sequences.
module tb_cdf_builder;

  localparam int NUM_BINS = 256;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  M1SP_ReadAddress;
  logic [127:0] M1SP_ReadBus = '0;
  logic         M2SP_WriteEnable;
  logic [15:0]  M2SP_WriteAddress;
  logic [127:0] M2SP_WriteBus;
  logic [19:0]  CdfMin;
  logic [19:0]  divisor;
  logic         done;

  cdf_builder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .M1SP_ReadAddress  (M1SP_ReadAddress),
    .M1SP_ReadBus      (M1SP_ReadBus),
    .M2SP_WriteEnable  (M2SP_WriteEnable),
    .M2SP_WriteAddress (M2SP_WriteAddress),
    .M2SP_WriteBus     (M2SP_WriteBus),
    .CdfMin            (CdfMin),
    .divisor           (divisor),
    .done              (done)
  );

  always #5 clock = ~clock;

  logic [19:0] hist    [NUM_BINS];
  logic [19:0] cdf_mem [NUM_BINS];
  logic [15:0] rd_addr_s = '0;
  int          wr_count = 0;
  int          wr_bad   = 0;
  int          idle_bad = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Synchronous M1 model: address seen in cycle n returns data in cycle n+1,
  // with junk in the upper bits that the design must ignore.
  always @(negedge clock) rd_addr_s <= M1SP_ReadAddress;
  always @(posedge clock) M1SP_ReadBus <= {{54{2'b10}}, hist[rd_addr_s[7:0]]};

  always @(negedge clock) begin
    if (M2SP_WriteEnable) begin
      cdf_mem[M2SP_WriteAddress[7:0]] <= M2SP_WriteBus[19:0];
      wr_count <= wr_count + 1;
      if (M2SP_WriteBus[127:20] != '0 || M2SP_WriteAddress >= 16'(NUM_BINS))
        wr_bad <= wr_bad + 1;
    end else if (M2SP_WriteAddress != '0 || M2SP_WriteBus != '0) begin
      idle_bad <= idle_bad + 1;
    end
  end

  typedef struct {
    int          pattern;
    logic [19:0] exp_min;
    logic [19:0] exp_div;
    int          bin_a;
    logic [19:0] exp_a;
    int          bin_b;
    logic [19:0] exp_b;
    int          bin_c;
    logic [19:0] exp_c;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic loadPattern(input int pattern);
    for (int i = 0; i < NUM_BINS; i++) begin
      case (pattern)
        0:       hist[i] = 20'd256;
        1:       hist[i] = (i < 10) ? 20'd0 : ((i == 10) ? 20'd5 : 20'd1);
        2:       hist[i] = (i == 37) ? 20'd65536 : 20'd0;
        3:       hist[i] = 20'd8192;
        default: hist[i] = 20'd0;
      endcase
      cdf_mem[i] = 20'hABCDE;
    end
  endtask

  // Pulses start for one cycle and returns how many cycles until done shows.
  task automatic applyStimulus(input int pattern, output int latency);
    loadPattern(pattern);
    @(negedge clock);
    start = 1'b1;
    latency = 0;
    while (latency < 400) begin
      @(negedge clock);
      start = 1'b0;
      latency++;
      if (done) break;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    int wr_base, bad_base, idle_base;
    wr_base   = wr_count;
    bad_base  = wr_bad;
    idle_base = idle_bad;
    applyStimulus(v.pattern, lat);
    checkOutput({tag, " done latency"}, lat, 259);
    checkOutput({tag, " CdfMin"}, 32'(CdfMin), 32'(v.exp_min));
    checkOutput({tag, " divisor"}, 32'(divisor), 32'(v.exp_div));
    @(negedge clock);
    checkOutput({tag, " done width"}, 32'(done), 0);
    checkOutput({tag, " write count"}, wr_count - wr_base, NUM_BINS);
    checkOutput({tag, " bad writes"}, wr_bad - bad_base, 0);
    checkOutput({tag, " idle bus"}, idle_bad - idle_base, 0);
    checkOutput({tag, " cdf probe a"}, 32'(cdf_mem[v.bin_a]), 32'(v.exp_a));
    checkOutput({tag, " cdf probe b"}, 32'(cdf_mem[v.bin_b]), 32'(v.exp_b));
    checkOutput({tag, " cdf probe c"}, 32'(cdf_mem[v.bin_c]), 32'(v.exp_c));
  endtask

  initial begin
    int wr_snap, cyc, n_done, first_done, second_done;
    logic [19:0] min1, div1;

    vecs[0] = '{0, 20'd256,   20'd65280,   0, 20'd256,     127, 20'd32768,   255, 20'd65536};
    vecs[1] = '{1, 20'd5,     20'd245,     9, 20'd0,       10,  20'd5,       255, 20'd250};
    vecs[2] = '{2, 20'd65536, 20'd1,       36, 20'd0,      37,  20'd65536,   255, 20'd65536};
    vecs[3] = '{3, 20'd8192,  20'd1040383, 126, 20'd1040384, 127, 20'hFFFFF, 255, 20'hFFFFF};
    vecs[4] = '{4, 20'd0,     20'd1,       0, 20'd0,       128, 20'd0,       255, 20'd0};

    loadPattern(4);
    repeat (3) @(negedge clock);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset CdfMin", 32'(CdfMin), 0);
    checkOutput("reset divisor", 32'(divisor), 0);
    checkOutput("reset write enable", 32'(M2SP_WriteEnable), 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Abort a flat build 100 cycles in; previous results must clear too.
    loadPattern(0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (99) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort done", 32'(done), 0);
    checkOutput("abort write enable", 32'(M2SP_WriteEnable), 0);
    checkOutput("abort CdfMin", 32'(CdfMin), 0);
    checkOutput("abort divisor", 32'(divisor), 0);
    checkOutput("abort read address", 32'(M1SP_ReadAddress), 0);
    checkOutput("abort write bus", 32'(M2SP_WriteBus[31:0]), 0);
    @(negedge clock);
    wr_snap = wr_count;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    checkOutput("abort no writes", wr_count - wr_snap, 0);
    runVector(vecs[0], "post-abort");

    // Start held high: exactly one done per build, next build right after done.
    loadPattern(1);
    @(negedge clock);
    start = 1'b1;
    n_done = 0;
    first_done = 0;
    second_done = 0;
    min1 = '0;
    div1 = '0;
    for (cyc = 1; cyc <= 525; cyc++) begin
      @(negedge clock);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = cyc;
          min1 = CdfMin;
          div1 = divisor;
        end else if (n_done == 2) begin
          second_done = cyc;
        end
      end
    end
    start = 1'b0;
    checkOutput("held start done count", n_done, 2);
    checkOutput("held start first done", first_done, 259);
    checkOutput("held start second done", second_done, 519);
    checkOutput("held start CdfMin 1", 32'(min1), 5);
    checkOutput("held start divisor 1", 32'(div1), 245);
    checkOutput("held start CdfMin 2", 32'(CdfMin), 32'(min1));
    checkOutput("held start divisor 2", 32'(divisor), 32'(div1));
    checkOutput("held start cdf last", 32'(cdf_mem[255]), 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
